// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the two-port MCU memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } arb_state_t;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DMA = 1'b1;

  localparam int DEF_AW      = 12;
  localparam int DEF_DW      = 16;
  localparam int DEF_TIMEOUT = 15;

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// Two-way round-robin picker: on a tie the port not granted last wins.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       id,
  output logic       vld
);

  always_comb begin
    vld = |req;
    id  = (req == 2'b11) ? ~last : req[1];
  end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises core (port 0) and loader/DMA (port 1) accesses onto the single
// MCU memory, with round-robin fairness and a ready timeout.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW      = DEF_AW,
  parameter int DW      = DEF_DW,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          ack0,
  output logic          ack1,
  output logic          err0,
  output logic          err1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic          busy,
  output logic          owner,
  output logic          mem_en,
  output logic          mem_w,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready
);

  localparam int CW = $clog2(TIMEOUT + 1);

  arb_state_t           state;
  logic [CW-1:0]        cnt;
  logic [1:0]           ack_q, err_q;
  logic [1:0][DW-1:0]   rdata_q;

  logic                 pick_id, pick_vld;
  logic                 sel_we;
  logic [AW-1:0]        sel_addr;
  logic [DW-1:0]        sel_wdata;
  logic                 tmo;

  rr_pick2 u_pick (
    .req  ({req1, req0}),
    .last (owner),
    .id   (pick_id),
    .vld  (pick_vld)
  );

  always_comb begin
    sel_we    = pick_id ? we1    : we0;
    sel_addr  = pick_id ? addr1  : addr0;
    sel_wdata = pick_id ? wdata1 : wdata0;
    tmo       = (cnt == CW'(TIMEOUT - 1));
  end

  // The mem_* registers double as the request latches: they are loaded at
  // grant and held for the whole ACCESS, so requester changes are ignored.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      owner     <= PORT_DMA;
      mem_en    <= 1'b0;
      mem_w     <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      ack_q     <= '0;
      err_q     <= '0;
      rdata_q   <= '0;
    end else begin
      ack_q <= '0;
      err_q <= '0;
      case (state)
        IDLE: begin
          if (pick_vld) begin
            owner     <= pick_id;
            mem_en    <= 1'b1;
            mem_w     <= sel_we;
            mem_addr  <= sel_addr;
            mem_wdata <= sel_we ? sel_wdata : '0;
            cnt       <= '0;
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          cnt <= cnt + 1'b1;
          if (mem_ready || tmo) begin
            if (mem_ready && !mem_w)
              rdata_q[owner] <= mem_rdata;
            ack_q[owner] <= 1'b1;
            err_q[owner] <= ~mem_ready;
            mem_en       <= 1'b0;
            mem_w        <= 1'b0;
            state        <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy   = (state != IDLE);
  assign ack0   = ack_q[0];
  assign ack1   = ack_q[1];
  assign err0   = err_q[0];
  assign err1   = err_q[1];
  assign rdata0 = rdata_q[0];
  assign rdata1 = rdata_q[1];

endmodule
